// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - scoreboarded multi-port register file with pending-write counters
module regfile_sb #(
    parameter int WORD   = 32,
    parameter int NREG   = 16,
    parameter int NRD    = 2,
    parameter int NWB    = 1,
    parameter int PEND_W = 2,
    parameter int BYPASS = 1,
    localparam int W_RD  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*W_RD-1:0] rd_name_i,
    output logic [NRD*WORD-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_reserved_o,
    input  logic                rsv_i,
    input  logic [W_RD-1:0]     rsv_name_i,
    output logic                rsv_ack_o,
    input  logic [NWB-1:0]      wb_i,
    input  logic [NWB*W_RD-1:0] wb_name_i,
    input  logic [NWB*WORD-1:0] wb_data_i,
    input  logic                flush_i,
    output logic                busy_o,
    output logic                err_o
);
    localparam int HW = $clog2(NWB + 1);
    localparam int CW = ((PEND_W > HW) ? PEND_W : HW) + 1;

    logic [WORD-1:0]   r_reg [NREG];
    logic [PEND_W-1:0] r_cnt [NREG];
    logic              r_busy;
    logic              r_err;

    logic [HW-1:0]     w_hits  [NREG];
    logic [WORD-1:0]   w_wdata [NREG];
    logic [PEND_W-1:0] w_dec   [NREG];
    logic [PEND_W-1:0] w_next  [NREG];
    logic [NREG-1:0]   w_under;
    logic              w_busy;
    logic              w_sat;

    // Per-register hit count and winning data; later ports override earlier ones.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            w_hits[r]  = '0;
            w_wdata[r] = '0;
            for (int j = 0; j < NWB; j++) begin
                if (wb_i[j] && (wb_name_i[j*W_RD +: W_RD] == W_RD'(r))) begin
                    w_hits[r]  = w_hits[r] + HW'(1);
                    w_wdata[r] = wb_data_i[j*WORD +: WORD];
                end
            end
            w_under[r] = CW'(w_hits[r]) > CW'(r_cnt[r]);
            w_dec[r]   = w_under[r] ? '0 : PEND_W'(CW'(r_cnt[r]) - CW'(w_hits[r]));
        end
    end

    // Saturation is judged after this cycle's retirements so a full register can still take a reserve.
    assign w_sat     = &w_dec[rsv_name_i];
    assign rsv_ack_o = rsv_i & ~flush_i & ~w_sat;

    always_comb begin
        w_busy = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            if (flush_i) begin
                w_next[r] = '0;
            end else begin
                w_next[r] = w_dec[r] + PEND_W'(rsv_ack_o && (rsv_name_i == W_RD'(r)));
            end
            w_busy = w_busy | (w_next[r] != '0);
        end
    end

    always_comb begin
        rd_data_o     = '0;
        rd_reserved_o = '0;
        for (int k = 0; k < NRD; k++) begin
            logic [W_RD-1:0] n;
            n = rd_name_i[k*W_RD +: W_RD];
            if ((BYPASS != 0) && (w_hits[n] != '0)) begin
                rd_data_o[k*WORD +: WORD] = w_wdata[n];
            end else begin
                rd_data_o[k*WORD +: WORD] = r_reg[n];
            end
            if (BYPASS != 0) begin
                rd_reserved_o[k] = (w_dec[n] != '0);
            end else begin
                rd_reserved_o[k] = (r_cnt[n] != '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                r_reg[r] <= '0;
                r_cnt[r] <= '0;
            end
            r_busy <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (w_hits[r] != '0) begin
                    r_reg[r] <= w_wdata[r];
                end
                r_cnt[r] <= w_next[r];
            end
            r_busy <= w_busy;
            r_err  <= r_err | (~flush_i & (|w_under));
        end
    end

    assign busy_o = r_busy;
    assign err_o  = r_err;
endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        rst;

    // Instance A: two write-back ports, bypass enabled
    logic [7:0]  a_rd_name;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_res;
    logic        a_rsv;
    logic [3:0]  a_rsv_name;
    logic        a_ack;
    logic [1:0]  a_wb;
    logic [7:0]  a_wb_name;
    logic [63:0] a_wb_data;
    logic        a_flush;
    logic        a_busy;
    logic        a_err;

    // Instance B: one write-back port, bypass disabled
    logic [7:0]  b_rd_name;
    logic [63:0] b_rd_data;
    logic [1:0]  b_rd_res;
    logic        b_rsv;
    logic [3:0]  b_rsv_name;
    logic        b_ack;
    logic [0:0]  b_wb;
    logic [3:0]  b_wb_name;
    logic [31:0] b_wb_data;
    logic        b_flush;
    logic        b_busy;
    logic        b_err;

    int n_assert = 0;
    int n_fail   = 0;

    regfile_sb #(.WORD(32), .NREG(16), .NRD(2), .NWB(2), .PEND_W(2), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst),
        .rd_name_i(a_rd_name), .rd_data_o(a_rd_data), .rd_reserved_o(a_rd_res),
        .rsv_i(a_rsv), .rsv_name_i(a_rsv_name), .rsv_ack_o(a_ack),
        .wb_i(a_wb), .wb_name_i(a_wb_name), .wb_data_i(a_wb_data),
        .flush_i(a_flush), .busy_o(a_busy), .err_o(a_err)
    );

    regfile_sb #(.WORD(32), .NREG(16), .NRD(2), .NWB(1), .PEND_W(2), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst),
        .rd_name_i(b_rd_name), .rd_data_o(b_rd_data), .rd_reserved_o(b_rd_res),
        .rsv_i(b_rsv), .rsv_name_i(b_rsv_name), .rsv_ack_o(b_ack),
        .wb_i(b_wb), .wb_name_i(b_wb_name), .wb_data_i(b_wb_data),
        .flush_i(b_flush), .busy_o(b_busy), .err_o(b_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic a_idle();
        a_rsv = 1'b0; a_rsv_name = '0; a_wb = '0; a_wb_name = '0; a_wb_data = '0; a_flush = 1'b0;
    endtask

    task automatic a_wb0(input logic [3:0] name, input logic [31:0] data);
        a_wb[0] = 1'b1; a_wb_name[3:0] = name; a_wb_data[31:0] = data;
    endtask

    initial begin
        rst = 1'b0;
        a_idle();
        a_rd_name = '0;
        b_rd_name = '0; b_rsv = 1'b0; b_rsv_name = '0; b_wb = '0; b_wb_name = '0;
        b_wb_data = '0; b_flush = 1'b0;
        tick();
        rst = 1'b1;

        // Preload r3, then reset for two cycles
        a_wb0(4'd3, 32'hDEADBEEF);
        tick();
        a_idle();
        a_rd_name = {4'd0, 4'd3};
        settle();
        chk("preload_r3", a_rd_data[31:0], 64'hDEADBEEF);
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        settle();
        chk("rst_data", a_rd_data[31:0], 64'h0);
        chk("rst_res", a_rd_res[0], 64'h0);
        chk("rst_busy", a_busy, 64'h0);
        chk("rst_err", a_err, 64'h0);

        // Basic reserve then bypassed write-back
        a_rsv = 1'b1; a_rsv_name = 4'd5;
        settle();
        chk("r5_ack", a_ack, 64'h1);
        tick();
        a_idle();
        a_rd_name = {4'd0, 4'd5};
        settle();
        chk("r5_res", a_rd_res[0], 64'h1);
        chk("r5_busy", a_busy, 64'h1);
        a_wb0(4'd5, 32'h1234);
        settle();
        chk("r5_byp_data", a_rd_data[31:0], 64'h1234);
        chk("r5_byp_res", a_rd_res[0], 64'h0);
        tick();
        a_idle();
        settle();
        chk("r5_busy_clr", a_busy, 64'h0);
        chk("r5_arr_data", a_rd_data[31:0], 64'h1234);

        // Saturation of r7 at three pending writes
        a_rd_name = {4'd0, 4'd7};
        for (int i = 0; i < 3; i++) begin
            a_rsv = 1'b1; a_rsv_name = 4'd7;
            settle();
            chk($sformatf("r7_ack%0d", i), a_ack, 64'h1);
            tick();
        end
        settle();
        chk("r7_sat_nak", a_ack, 64'h0);
        a_wb0(4'd7, 32'h70);
        settle();
        chk("r7_sat_wb_ack", a_ack, 64'h1);
        tick();
        a_idle();
        a_wb0(4'd7, 32'h71);
        settle();
        chk("r7_wb1_res", a_rd_res[0], 64'h1);
        tick();
        settle();
        chk("r7_wb2_res", a_rd_res[0], 64'h1);
        tick();
        settle();
        chk("r7_wb3_res", a_rd_res[0], 64'h0);
        tick();
        a_idle();
        settle();
        chk("r7_res_end", a_rd_res[0], 64'h0);
        chk("r7_err", a_err, 64'h0);
        chk("r7_busy", a_busy, 64'h0);

        // Dual write-back to r2 with matching count
        a_rd_name = {4'd0, 4'd2};
        a_rsv = 1'b1; a_rsv_name = 4'd2;
        tick();
        tick();
        a_idle();
        a_wb = 2'b11; a_wb_name = {4'd2, 4'd2}; a_wb_data = {32'hB, 32'hA};
        settle();
        chk("dual_byp_data", a_rd_data[31:0], 64'hB);
        chk("dual_byp_res", a_rd_res[0], 64'h0);
        tick();
        a_idle();
        settle();
        chk("dual_arr_data", a_rd_data[31:0], 64'hB);
        chk("dual_err", a_err, 64'h0);
        chk("dual_busy", a_busy, 64'h0);

        // Dual write-back with only one pending write: underflow
        a_rsv = 1'b1; a_rsv_name = 4'd2;
        tick();
        a_idle();
        a_wb = 2'b11; a_wb_name = {4'd2, 4'd2}; a_wb_data = {32'hD, 32'hC};
        tick();
        a_idle();
        settle();
        chk("under_err", a_err, 64'h1);
        chk("under_data", a_rd_data[31:0], 64'hD);
        tick();
        chk("under_err_sticky", a_err, 64'h1);

        // Flush drops reservations; clear err with a reset first
        rst = 1'b0;
        tick();
        rst = 1'b1;
        a_rsv = 1'b1; a_rsv_name = 4'd1;
        tick();
        tick();
        a_rsv_name = 4'd4;
        tick();
        a_idle();
        a_rd_name = {4'd4, 4'd1};
        settle();
        chk("pre_flush_res", a_rd_res, 64'h3);
        a_flush = 1'b1; a_rsv = 1'b1; a_rsv_name = 4'd6;
        a_wb0(4'd4, 32'h55);
        settle();
        chk("flush_ack", a_ack, 64'h0);
        tick();
        a_idle();
        settle();
        chk("flush_res", a_rd_res, 64'h0);
        chk("flush_busy", a_busy, 64'h0);
        chk("flush_r4_data", a_rd_data[63:32], 64'h55);
        chk("flush_err", a_err, 64'h0);
        a_rd_name = {4'd0, 4'd6};
        settle();
        chk("flush_r6_res", a_rd_res[0], 64'h0);

        // No-bypass instance: same-cycle read sees old state
        b_rd_name = {4'd0, 4'd9};
        b_rsv = 1'b1; b_rsv_name = 4'd9;
        settle();
        chk("b_ack", b_ack, 64'h1);
        tick();
        b_rsv = 1'b0;
        b_wb = 1'b1; b_wb_name = 4'd9; b_wb_data = 32'h77;
        settle();
        chk("b_same_data", b_rd_data[31:0], 64'h0);
        chk("b_same_res", b_rd_res[0], 64'h1);
        tick();
        b_wb = 1'b0;
        settle();
        chk("b_next_data", b_rd_data[31:0], 64'h77);
        chk("b_next_res", b_rd_res[0], 64'h0);
        chk("b_err", b_err, 64'h0);
        chk("b_busy", b_busy, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised scoreboarded register file for the Venus pipeline. ID reads operands and reserves destination registers through it, and EX retires results into it. Compared with the single-port register file it adds:
- configurable register count, data width, read ports and write-back ports;
- a per-register pending-write counter, so several in-flight writes to one register are allowed;
- same-cycle write-back bypass;
- a pipeline-flush input that drops all reservations.

## Interface
Parameters:
- WORD, 32: data width in bits.
- NREG, 16: number of registers (power of two, ≥2); W_RD = log2(NREG).
- NRD, 2: number of combinational read ports.
- NWB, 1: number of write-back ports (1–4).
- PEND_W, 2: pending-counter width; at most 2^PEND_W−1 outstanding writes per register.
- BYPASS, 1: 1 forwards same-cycle write-back data to the read ports; 0 disables forwarding.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-low (rst=0 at a rising edge resets).
- rd_name_i  in  NRD*W_RD  read register names; port k uses bits [k*W_RD +: W_RD].
- rd_data_o  out  NRD*WORD  read data, combinational.
- rd_reserved_o  out  NRD  1 means the named register still has pending writes after this cycle's write-backs.
- rsv_i  in  1  reserve request from ID.
- rsv_name_i  in  W_RD  register to reserve.
- rsv_ack_o  out  1  combinational; 1 means the reserve is accepted this cycle.
- wb_i  in  NWB  write-back valid, one bit per port.
- wb_name_i  in  NWB*W_RD  write-back register names.
- wb_data_i  in  NWB*WORD  write-back data.
- flush_i  in  1  clears every pending counter.
- busy_o  out  1  registered; 1 when any pending counter is non-zero.
- err_o  out  1  registered, sticky; write-back underflow detected.

## Operation
- State:
  - data array reg[NREG][WORD];
  - counter cnt[NREG][PEND_W];
  - busy_o and err_o.
- Reset (rst=0 at an edge): all reg and cnt values become 0; busy_o=0, err_o=0. Reset overrides every other input that cycle.
- Reserve acceptance:
  - rsv_ack_o = rsv_i & ~flush_i & (cnt[rsv_name_i] != all-ones), evaluated after this cycle's decrement.
  - So a saturated register that is being written back this cycle does accept the reserve.
  - When rsv_ack_o=0, ID must stall and retry; the block keeps no memory of refused requests.
- Write-back:
  - For each register r, hits(r) is the number of ports j with wb_i[j]=1 and wb_name_i[j]=r.
  - reg[r] takes data from the highest-index hitting port.
  - Writes happen regardless of counter value.
- Counter update (non-flush cycle): cnt[r] ← cnt[r] − hits(r) + (rsv_ack_o & rsv_name_i==r).
- Underflow: if hits(r) > cnt[r], cnt[r] ← 0 plus the accepted reserve (if any), and err_o ← 1 on the same edge.
- Flush (flush_i=1): every cnt ← 0 and no reserve is accepted. Write-back data is still written. Underflow is not flagged in a flush cycle.
- Read port k, with name n:
  - BYPASS=1 and some wb hits n: rd_data_o = the highest-index hitting port's wb_data_i.
  - Otherwise: rd_data_o = reg[n].
  - rd_reserved_o[k] = (cnt[n] − hits(n)) != 0 when BYPASS=1, or cnt[n] != 0 when BYPASS=0. A reserve in the same cycle does not affect it.
- busy_o ← OR over all registers of next-state cnt != 0.

## Timing
- Read path is combinational, zero latency; written data is visible from the array on the cycle after the write.
- With BYPASS=1, write-back data and reservation release are visible on the same cycle.
- An accepted reserve shows as rd_reserved_o=1 from the next cycle.
- Flush takes effect at the edge: from the next cycle all rd_reserved_o=0 and busy_o=0, unless a reserve is made after the flush.
- Reset mid-operation discards all pending counts and data. Write-backs arriving after reset are flagged as underflow.
- err_o clears only on reset.

## Test plan
- **Reset:** hold rst=0 for 2 cycles with reg[3] previously holding 0xDEADBEEF, then read r3 → rd_data_o=0, rd_reserved_o=0, busy_o=0, err_o=0.
- **Basic reserve and write:** reserve r5; next cycle read r5 → reserved=1, busy_o=1. Then wb r5=0x1234 with BYPASS=1 → same cycle data=0x1234, reserved=0; next cycle busy_o=0.
- **Saturation (PEND_W=2):**
  - 3 reserves of r7 → ack=1 each time; 4th → ack=0.
  - 4th reserve plus wb r7 in the same cycle → ack=1, cnt stays 3.
  - Three further wbs → reserved=0.
- **Dual write-back (NWB=2):**
  - Ports 0 and 1 both write r2, with 0xA and 0xB, and cnt[r2]=2 → reg[r2]=0xB, cnt=0, err_o=0.
  - Same with cnt[r2]=1 → err_o=1 next cycle and stays 1.
- **Flush:**
  - cnt r1=2, r4=1; assert flush_i together with rsv r6 and wb r4=0x55 → ack=0.
  - Next cycle: all reserved=0, busy_o=0, reg[r4]=0x55, err_o=0.
- **BYPASS=0:** wb r9=0x77 with cnt=1 → same-cycle read returns old data and reserved=1; next cycle returns 0x77 and reserved=0.
